wb_arb_stage: RTL and testbench
===============================

// Module: wb_arb_stage
// PURPOSE
//  Parametrised write-back stage. Merges two result sources into one registered register-file write port.
//  Source A is the in-order MEM/WB pipeline: ALU result, or load data with byte/half extraction and sign/zero extension.
//  Source B is late results (multi-cycle units), taken with valid/ready and held in a FIFO.
//  A has absolute priority. B drains in idle slots; a starvation counter requests a pipeline bubble.
// PARAMETERS
//  DATA_W        32  datapath width; multiple of 16
//  REG_AW        4   register address width; NUM_REGS = 2**REG_AW
//  DEPTH         4   source-B FIFO entries (>=2)
//  STARVE_LIMIT  8   consecutive A-win cycles with FIFO non-empty before stall_req
//  ZERO_REG_DISC 1   1: writes to register 0 from either source are discarded
// PORTS
//  clk            in   1        clock, rising edge
//  reset          in   1        asynchronous, active-high
//  enable         in   1        0: freeze FIFO/counters; rf_we forced 0; b_ready=0
//  a_reg_write_en in   1        source-A write request
//  a_mem_to_reg   in   1        1: select load data; 0: select ALU result
//  a_alu_result   in   DATA_W   ALU result; low bits give the load byte offset
//  a_mem_rdata    in   DATA_W   raw memory word
//  a_load_size    in   2        00 byte, 01 half, 10/11 full word
//  a_load_signed  in   1        1: sign-extend sub-word load
//  a_rd           in   REG_AW   source-A destination
//  b_valid        in   1        source-B result valid
//  b_ready        out  1        = enable && (fifo_count != DEPTH)
//  b_rd           in   REG_AW   source-B destination
//  b_data         in   DATA_W   source-B data
//  rf_we          out  1        registered RF write enable
//  rf_waddr       out  REG_AW   registered RF write address
//  rf_wdata       out  DATA_W   registered RF write data
//  fifo_count     out  clog2(DEPTH+1)  valid FIFO entries
//  pending_mask   out  NUM_REGS bit i=1 iff a valid FIFO entry targets reg i
//  stall_req      out  1        registered request for a pipeline bubble
// BEHAVIOUR
//  Reset (async): rf_we=0, rf_waddr=0, rf_wdata=0, FIFO empty, fifo_count=0, pending_mask=0, stall_req=0, starve_cnt=0.
//  Reset asserted mid-operation discards all FIFO contents at once.
//  a_win = a_reg_write_en && !(ZERO_REG_DISC && a_rd==0).
//  Load extraction: byte at offset a_alu_result[1:0]; half at offset a_alu_result[1]*16 (bit0 ignored).
//  Extension is by a_load_signed; extraction is little-endian.
//  Cycle t, enable=1:
//    if a_win: at t+1 rf_we=1, rf_waddr=a_rd, rf_wdata=selected A data.
//    else if FIFO non-empty: pop head; at t+1 rf_we=1 with the head's rd/data.
//    else at t+1 rf_we=0; rf_waddr/rf_wdata hold their previous values.
//  Push: b_valid && b_ready at edge t. If ZERO_REG_DISC && b_rd==0, accepted but not stored.
//  No FIFO bypass: a B result reaches rf_we at t+2 at the earliest.
//  Push and pop in the same cycle: count unchanged. Full FIFO: b_ready=0 even when a pop occurs that cycle.
//  Pointers wrap modulo DEPTH. FIFO order is preserved.
//  pending_mask is derived from the stored valid entries. A bit clears on the edge that pops its last entry.
//  Same-reg ordering between A and B is the issue logic's job, using pending_mask.
//  starve_cnt: +1 on each a_win cycle with FIFO non-empty; saturates at STARVE_LIMIT; cleared on any pop or when FIFO empty.
//    stall_req <= (starve_cnt_next >= STARVE_LIMIT).
//    stall_req stays high until the first B pop, then drops on the following edge.
//  enable=0: no push, no pop, rf_we<=0, starve_cnt/stall_req hold.
// TESTING
//  ALU write: a_we=1, mem_to_reg=0, alu=100, rd=1 -> next cycle rf_we=1, waddr=1, wdata=100.
//  Loads: mem=FACEB00C, alu[1:0]=2, signed byte -> FFFFFFCE; alu[1:0]=0, unsigned half -> 0000B00C.
//  B path: A idle, push rd=5, data=55 at t -> pending_mask[5]=1, count=1 at t+1.
//    -> rf_we/waddr=5/wdata=55 at t+2; mask=0, count=0 after t+2.
//  R0 discard: a_rd=0 with a_we=1 and FIFO non-empty -> B entry drains that slot. B push rd=0 -> count stays 0.
//  Full+starve (DEPTH=4, STARVE_LIMIT=4): A writes every cycle, push 5.
//    -> b_ready=0 at count=4; 5th held; stall_req=1 after 4 A-win cycles.
//    -> A idles 1 cycle: one pop; stall_req=0 next edge; count=3.
//  Reset mid-run with 3 entries -> rf_we=0, count=0, mask=0, stall_req=0 immediately; b_ready=1 after release.

Source files
------------

// File: rtl/wb_arb_stage.sv
// wb_arb_stage: merges in-order pipeline results and FIFO-buffered late results into one registered RF write port
module wb_arb_stage #(
  parameter int DATA_W        = 32,
  parameter int REG_AW        = 4,
  parameter int DEPTH         = 4,
  parameter int STARVE_LIMIT  = 8,
  parameter int ZERO_REG_DISC = 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         enable_i,
  input  logic                         a_reg_write_en_i,
  input  logic                         a_mem_to_reg_i,
  input  logic [DATA_W-1:0]            a_alu_result_i,
  input  logic [DATA_W-1:0]            a_mem_rdata_i,
  input  logic [1:0]                   a_load_size_i,
  input  logic                         a_load_signed_i,
  input  logic [REG_AW-1:0]            a_rd_i,
  input  logic                         b_valid_i,
  output logic                         b_ready_o,
  input  logic [REG_AW-1:0]            b_rd_i,
  input  logic [DATA_W-1:0]            b_data_i,
  output logic                         rf_we_o,
  output logic [REG_AW-1:0]            rf_waddr_o,
  output logic [DATA_W-1:0]            rf_wdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count_o,
  output logic [2**REG_AW-1:0]         pending_mask_o,
  output logic                         stall_req_o
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT+1);
  logic [REG_AW-1:0] rd_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic stall_q, stall_d;
  logic rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [7:0] ld_byte;
  logic [15:0] ld_half;
  logic [DATA_W-1:0] a_data;
  logic a_win, empty, pop, push, store;
  assign a_win   = a_reg_write_en_i && !(ZERO_REG_DISC != 0 && a_rd_i == '0);
  assign empty   = count_q == '0;
  assign pop     = enable_i && !a_win && !empty;
  assign b_ready_o = enable_i && count_q != CW'(DEPTH);
  assign push    = b_valid_i && b_ready_o;
  assign store   = push && !(ZERO_REG_DISC != 0 && b_rd_i == '0);
  // Little-endian sub-word extraction; half-word offset ignores address bit 0
  assign ld_byte = a_mem_rdata_i[8*a_alu_result_i[1:0] +: 8];
  assign ld_half = a_mem_rdata_i[16*a_alu_result_i[1] +: 16];
  assign a_data  = !a_mem_to_reg_i ? a_alu_result_i :
                   a_load_size_i == 2'b00 ? {{(DATA_W-8){a_load_signed_i & ld_byte[7]}}, ld_byte} :
                   a_load_size_i == 2'b01 ? {{(DATA_W-16){a_load_signed_i & ld_half[15]}}, ld_half} :
                   a_mem_rdata_i;
  // Next-state: FIFO pointers, starvation tracking and the write-port selection (A first, then FIFO head)
  always_comb begin
    head_d     = pop ? (head_q == PW'(DEPTH-1) ? '0 : head_q + PW'(1)) : head_q;
    tail_d     = store ? (tail_q == PW'(DEPTH-1) ? '0 : tail_q + PW'(1)) : tail_q;
    count_d    = count_q + CW'(store) - CW'(pop);
    starve_d   = !enable_i ? starve_q : (pop || empty) ? '0 :
                 (a_win && starve_q < SW'(STARVE_LIMIT)) ? starve_q + SW'(1) : starve_q;
    stall_d    = enable_i ? starve_d >= SW'(STARVE_LIMIT) : stall_q;
    rf_we_d    = enable_i && (a_win || pop);
    rf_waddr_d = (enable_i && a_win) ? a_rd_i : pop ? rd_q[head_q] : rf_waddr_q;
    rf_wdata_d = (enable_i && a_win) ? a_data : pop ? data_q[head_q] : rf_wdata_q;
  end
  // Control state; reset empties the FIFO instantly by clearing pointers and count
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      stall_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  // FIFO payload storage needs no reset; validity comes from head/count
  always_ff @(posedge clk_i)
    if (store) begin
      rd_q[tail_q]   <= b_rd_i;
      data_q[tail_q] <= b_data_i;
    end
  // Pending mask: OR of destinations of all slots lying within [head, head+count)
  always_comb begin
    pending_mask_o = '0;
    for (int i = 0; i < DEPTH; i++)
      if (((i >= int'(head_q)) ? i - int'(head_q) : i + DEPTH - int'(head_q)) < int'(count_q))
        pending_mask_o[rd_q[i]] = 1'b1;
  end
  assign rf_we_o      = rf_we_q;
  assign rf_waddr_o   = rf_waddr_q;
  assign rf_wdata_o   = rf_wdata_q;
  assign fifo_count_o = count_q;
  assign stall_req_o  = stall_q;
endmodule

// File: tb/tb_wb_arb_stage.sv
// tb_wb_arb_stage: directed vector table for the A path plus hand sequences for FIFO, starvation and reset
module tb_wb_arb_stage;
  logic clk_i = 1'b0, reset_i = 1'b1, enable_i = 1'b1;
  logic a_we = 1'b0, a_m2r = 1'b0, a_sgn = 1'b0, b_valid = 1'b0;
  logic [31:0] a_alu = '0, a_mem = '0, b_data = '0;
  logic [1:0] a_size = '0;
  logic [3:0] a_rd = '0, b_rd = '0;
  logic b_ready, rf_we, stall_req;
  logic [3:0] rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0] fifo_count;
  logic [15:0] pending_mask;
  int total = 0, bad = 0;

  wb_arb_stage #(.DATA_W(32), .REG_AW(4), .DEPTH(4), .STARVE_LIMIT(4), .ZERO_REG_DISC(1)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i),
    .a_reg_write_en_i(a_we), .a_mem_to_reg_i(a_m2r), .a_alu_result_i(a_alu),
    .a_mem_rdata_i(a_mem), .a_load_size_i(a_size), .a_load_signed_i(a_sgn), .a_rd_i(a_rd),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_rd_i(b_rd), .b_data_i(b_data),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .fifo_count_o(fifo_count), .pending_mask_o(pending_mask), .stall_req_o(stall_req)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic we, m2r, sgn;
    logic [1:0] size;
    logic [31:0] alu, mem;
    logic [3:0] rd;
    logic exp_we;
    logic [3:0] exp_waddr;
    logic [31:0] exp_wdata;
  } vec_t;
  vec_t vt [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    vt[0]  = '{1, 0, 0, 2'd0, 32'd100,      32'hFACEB00C, 4'd1,  1, 4'd1,  32'd100};
    vt[1]  = '{1, 1, 1, 2'd0, 32'd2,        32'hFACEB00C, 4'd2,  1, 4'd2,  32'hFFFFFFCE};
    vt[2]  = '{1, 1, 0, 2'd1, 32'd0,        32'hFACEB00C, 4'd3,  1, 4'd3,  32'h0000B00C};
    vt[3]  = '{1, 1, 1, 2'd1, 32'd3,        32'hFACEB00C, 4'd4,  1, 4'd4,  32'hFFFFFACE};
    vt[4]  = '{1, 1, 0, 2'd0, 32'd7,        32'hFACEB00C, 4'd5,  1, 4'd5,  32'h000000FA};
    vt[5]  = '{1, 1, 1, 2'd0, 32'd1,        32'hFACEB00C, 4'd6,  1, 4'd6,  32'hFFFFFFB0};
    vt[6]  = '{1, 1, 1, 2'd1, 32'h10,       32'hFACEB00C, 4'd7,  1, 4'd7,  32'hFFFFB00C};
    vt[7]  = '{1, 1, 1, 2'd2, 32'h4,        32'hFACEB00C, 4'd8,  1, 4'd8,  32'hFACEB00C};
    vt[8]  = '{1, 1, 0, 2'd3, 32'h8,        32'hFACEB00C, 4'd9,  1, 4'd9,  32'hFACEB00C};
    vt[9]  = '{1, 1, 0, 2'd0, 32'h20,       32'hFACEB00C, 4'd10, 1, 4'd10, 32'h0000000C};
    vt[10] = '{0, 0, 0, 2'd0, 32'h1234,     32'h0,        4'd11, 0, 4'd10, 32'h0000000C};
    vt[11] = '{1, 0, 0, 2'd0, 32'h5678,     32'h0,        4'd0,  0, 4'd10, 32'h0000000C};
    vt[12] = '{1, 0, 1, 2'd0, 32'hDEADBEEF, 32'hFACEB00C, 4'd15, 1, 4'd15, 32'hDEADBEEF};

    repeat (2) tick;
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_mask", pending_mask, 0);
    chk("rst_stall", stall_req, 0);
    reset_i = 1'b0;

    for (int i = 0; i < 13; i++) begin
      a_we = vt[i].we; a_m2r = vt[i].m2r; a_sgn = vt[i].sgn; a_size = vt[i].size;
      a_alu = vt[i].alu; a_mem = vt[i].mem; a_rd = vt[i].rd;
      tick;
      chk($sformatf("v%0d_we", i), rf_we, vt[i].exp_we);
      chk($sformatf("v%0d_waddr", i), rf_waddr, vt[i].exp_waddr);
      chk($sformatf("v%0d_wdata", i), rf_wdata, vt[i].exp_wdata);
    end
    a_we = 0; a_m2r = 0;

    // B path: no bypass, lands two edges after the push
    b_valid = 1; b_rd = 5; b_data = 32'd55;
    chk("b_ready_idle", b_ready, 1);
    tick;
    b_valid = 0;
    chk("b_mask1", pending_mask, 16'h0020);
    chk("b_count1", fifo_count, 1);
    chk("b_nobypass", rf_we, 0);
    tick;
    chk("b_we", rf_we, 1);
    chk("b_waddr", rf_waddr, 5);
    chk("b_wdata", rf_wdata, 55);
    chk("b_count0", fifo_count, 0);
    chk("b_mask0", pending_mask, 0);

    // A write to r0 is discarded so the B entry takes that slot
    b_valid = 1; b_rd = 9; b_data = 32'h99;
    tick;
    b_valid = 0; a_we = 1; a_rd = 0; a_alu = 32'h777;
    tick;
    chk("r0_we", rf_we, 1);
    chk("r0_waddr", rf_waddr, 9);
    chk("r0_wdata", rf_wdata, 32'h99);
    chk("r0_count", fifo_count, 0);
    a_we = 0;
    b_valid = 1; b_rd = 0; b_data = 32'hBAD;
    chk("r0b_ready", b_ready, 1);
    tick;
    b_valid = 0;
    chk("r0b_count", fifo_count, 0);
    chk("r0b_mask", pending_mask, 0);
    tick;
    chk("r0b_we", rf_we, 0);

    // Disabled: no push, rf_we forced low
    enable_i = 0; b_valid = 1; b_rd = 3; a_we = 1; a_rd = 4;
    #1 chk("dis_ready", b_ready, 0);
    tick;
    chk("dis_we", rf_we, 0);
    chk("dis_count", fifo_count, 0);
    enable_i = 1; b_valid = 0; a_we = 0;
    tick;

    // Fill to full while A wins every cycle; starvation raises stall_req
    a_we = 1; a_rd = 1;
    for (int c = 0; c < 6; c++) begin
      a_alu = c;
      b_valid = 1; b_rd = 4'(2 + (c < 4 ? c : 4)); b_data = 32'h100 + (c < 4 ? c + 2 : 6);
      chk($sformatf("full_ready%0d", c), b_ready, c < 4);
      tick;
      chk($sformatf("full_we%0d", c), rf_we, 1);
      chk($sformatf("full_wa%0d", c), rf_waddr, 1);
      chk($sformatf("full_wd%0d", c), rf_wdata, c);
      chk($sformatf("full_cnt%0d", c), fifo_count, c < 4 ? c + 1 : 4);
      chk($sformatf("full_stall%0d", c), stall_req, c >= 4);
    end
    chk("full_mask", pending_mask, 16'h003C);
    a_we = 0;
    chk("full_ready_pop", b_ready, 0);
    tick;
    chk("pop_we", rf_we, 1);
    chk("pop_waddr", rf_waddr, 2);
    chk("pop_wdata", rf_wdata, 32'h102);
    chk("pop_stall", stall_req, 0);
    chk("pop_count", fifo_count, 3);
    chk("pop_mask", pending_mask, 16'h0038);
    b_valid = 0;

    // Async reset with three entries held
    a_we = 1;
    reset_i = 1;
    #1;
    chk("mid_rst_we", rf_we, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_mask", pending_mask, 0);
    chk("mid_rst_stall", stall_req, 0);
    tick;
    reset_i = 0; a_we = 0;
    #1 chk("post_rst_ready", b_ready, 1);
    tick;
    chk("post_rst_we", rf_we, 0);
    chk("post_rst_count", fifo_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
